// File: rtl/tick_timer.sv
// -----------------------------------------------------------------------------
// tick_timer
//
// Programmable down-counting timer driven by the one-cycle-in-three pulse of
// the divide-by-3 tick generator.  Each accepted tick decrements the count.
// When a tick lands on a count of 1 the timer expires:
//   - a one-cycle expire pulse is raised;
//   - the sticky irq flag is set;
//   - one-shot mode returns to IDLE, periodic mode reloads from the shadow load.
// The timer can be paused (HOLD), resumed, restarted or aborted.
//
// Ports
//   clk       in   system clock, rising edge
//   res       in   asynchronous active-low reset
//   tick      in   count enable (any pattern legal, including held high)
//   start     in   start / restart / resume request (level-sampled)
//   stop      in   pause / abort request (level-sampled)
//   mode      in   0 = one-shot, 1 = periodic (sampled with start)
//   load_val  in   initial / reload count (sampled with start)
//   count     out  current count, registered
//   busy      out  high while in RUN or HOLD
//   expire    out  registered one-cycle pulse per expiry
//   irq       out  sticky expiry flag
//   irq_clr   in   clears irq (a same-cycle expiry wins)
// -----------------------------------------------------------------------------
module tick_timer #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         res,
    input  logic         tick,
    input  logic         start,
    input  logic         stop,
    input  logic         mode,
    input  logic [W-1:0] load_val,
    output logic [W-1:0] count,
    output logic         busy,
    output logic         expire,
    output logic         irq,
    input  logic         irq_clr
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    localparam logic [W-1:0] ZERO = '0;
    localparam logic [W-1:0] ONE  = W'(1);

    state_t       state_q, state_d;
    logic [W-1:0] count_q, count_d;
    logic [W-1:0] load_q,  load_d;
    logic         mode_q,  mode_d;
    logic         expire_q, expire_d;
    logic         irq_q,   irq_d;

    logic         load_nz;

    assign load_nz = (load_val != ZERO);

    // Next-state decode.  Within a cycle stop beats start, and start beats
    // tick, so a tick arriving alongside either request is simply dropped.
    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        load_d   = load_q;
        mode_d   = mode_q;
        expire_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (!stop && start && load_nz) begin
                    state_d = ST_RUN;
                    count_d = load_val;
                    load_d  = load_val;
                    mode_d  = mode;
                end
            end

            ST_RUN: begin
                if (stop) begin
                    state_d = ST_HOLD;
                end else if (start) begin
                    if (load_nz) begin
                        count_d = load_val;
                        load_d  = load_val;
                        mode_d  = mode;
                    end else begin
                        // A zero restart value is an abort that also clears.
                        state_d = ST_IDLE;
                        count_d = ZERO;
                    end
                end else if (tick) begin
                    if (count_q > ONE) begin
                        count_d = count_q - ONE;
                    end else begin
                        // Count of 1 (0 cannot occur in RUN) expires here,
                        // so the count never goes below 1 while running.
                        expire_d = 1'b1;
                        if (mode_q) begin
                            count_d = load_q;
                        end else begin
                            state_d = ST_IDLE;
                            count_d = ZERO;
                        end
                    end
                end
            end

            ST_HOLD: begin
                if (stop) begin
                    state_d = ST_IDLE;
                    count_d = ZERO;
                end else if (start) begin
                    state_d = ST_RUN;
                end
            end

            default: begin
                state_d = ST_IDLE;
                count_d = ZERO;
            end
        endcase
    end

    // Expiry takes precedence over a coincident clear.
    assign irq_d = expire_d | (irq_q & ~irq_clr);

    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            state_q  <= ST_IDLE;
            count_q  <= ZERO;
            load_q   <= ZERO;
            mode_q   <= 1'b0;
            expire_q <= 1'b0;
            irq_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            load_q   <= load_d;
            mode_q   <= mode_d;
            expire_q <= expire_d;
            irq_q    <= irq_d;
        end
    end

    assign count  = count_q;
    assign busy   = (state_q != ST_IDLE);
    assign expire = expire_q;
    assign irq    = irq_q;

endmodule

// File: tb/tb_tick_timer.sv
// -----------------------------------------------------------------------------
// tb_tick_timer
//
// Directed bench for tick_timer.  A behavioural model tracks the timer as
// "active / paused / remaining ticks" and is compared against the DUT on every
// falling clock edge; hand-computed literal expectations at key points pin the
// model itself.
// -----------------------------------------------------------------------------
module tb_tick_timer;

    localparam int W = 8;

    logic         clk;
    logic         res;
    logic         tick;
    logic         start;
    logic         stop;
    logic         mode;
    logic [W-1:0] load_val;
    logic [W-1:0] count;
    logic         busy;
    logic         expire;
    logic         irq;
    logic         irq_clr;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    bit chk_en = 0;

    tick_timer #(.W(W)) dut (
        .clk      (clk),
        .res      (res),
        .tick     (tick),
        .start    (start),
        .stop     (stop),
        .mode     (mode),
        .load_val (load_val),
        .count    (count),
        .busy     (busy),
        .expire   (expire),
        .irq      (irq),
        .irq_clr  (irq_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d at t=%0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    bit         m_active;
    bit         m_paused;
    bit         m_periodic;
    int         m_remaining;
    int         m_reload;
    bit         m_expire;
    bit         m_irq;

    always @(posedge clk or negedge res) begin
        if (!res) begin
            m_active    = 0;
            m_paused    = 0;
            m_periodic  = 0;
            m_remaining = 0;
            m_reload    = 0;
            m_expire    = 0;
            m_irq       = 0;
        end else begin
            bit fired;
            fired = 0;
            if (!m_active) begin
                if (!stop && start && load_val != 0) begin
                    m_active    = 1;
                    m_paused    = 0;
                    m_reload    = int'(load_val);
                    m_periodic  = mode;
                    m_remaining = int'(load_val);
                end
            end else if (m_paused) begin
                if (stop) begin
                    m_active    = 0;
                    m_paused    = 0;
                    m_remaining = 0;
                end else if (start) begin
                    m_paused = 0;
                end
            end else begin
                if (stop) begin
                    m_paused = 1;
                end else if (start) begin
                    if (load_val == 0) begin
                        m_active    = 0;
                        m_remaining = 0;
                    end else begin
                        m_reload    = int'(load_val);
                        m_periodic  = mode;
                        m_remaining = int'(load_val);
                    end
                end else if (tick) begin
                    m_remaining = m_remaining - 1;
                    if (m_remaining == 0) begin
                        fired = 1;
                        if (m_periodic) m_remaining = m_reload;
                        else            m_active    = 0;
                    end
                end
            end
            m_expire = fired;
            if (fired)        m_irq = 1;
            else if (irq_clr) m_irq = 0;
        end
    end

    // Cycle-by-cycle comparison, half a period away from the active edge.
    always @(negedge clk) begin
        if (chk_en) begin
            check("cmp_count",  int'(count),  m_remaining);
            check("cmp_busy",   int'(busy),   int'(m_active));
            check("cmp_expire", int'(expire), int'(m_expire));
            check("cmp_irq",    int'(irq),    int'(m_irq));
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            cyc++;
        end
    endtask

    // Two quiet cycles then one tick cycle: tick on every 3rd clk.
    task automatic tick3();
        tick = 1'b0;
        step(2);
        tick = 1'b1;
        step(1);
        tick = 1'b0;
    endtask

    task automatic do_start(input int lv, input bit md);
        start    = 1'b1;
        load_val = W'(lv);
        mode     = md;
        step(1);
        start    = 1'b0;
    endtask

    task automatic clear_irq();
        irq_clr = 1'b1;
        step(1);
        irq_clr = 1'b0;
    endtask

    int t1, t2, n;

    initial begin
        res      = 1'b0;
        tick     = 1'b0;
        start    = 1'b0;
        stop     = 1'b0;
        mode     = 1'b0;
        load_val = '0;
        irq_clr  = 1'b0;
        chk_en   = 1'b1;

        // Reset state
        step(2);
        check("rst_count",  int'(count),  0);
        check("rst_busy",   int'(busy),   0);
        check("rst_expire", int'(expire), 0);
        check("rst_irq",    int'(irq),    0);
        res = 1'b1;
        step(1);

        // One-shot, load 4: 4,3,2,1,0
        do_start(4, 1'b0);
        check("os_load", int'(count), 4);
        for (int k = 1; k <= 3; k++) begin
            tick3();
            check("os_count", int'(count), 4 - k);
        end
        tick3();
        check("os_exp_count",  int'(count),  0);
        check("os_exp_expire", int'(expire), 1);
        check("os_exp_busy",   int'(busy),   0);
        check("os_exp_irq",    int'(irq),    1);
        step(1);
        check("os_exp_pulse_len", int'(expire), 0);
        clear_irq();
        check("os_irq_cleared", int'(irq), 0);

        // Periodic, load 2: 2,1,2,1 with expiry every 6 clk
        do_start(2, 1'b1);
        check("per_load", int'(count), 2);
        tick3();
        check("per_c1", int'(count), 1);
        tick3();
        t1 = cyc;
        check("per_exp1",   int'(expire), 1);
        check("per_reload", int'(count),  2);
        check("per_irq1",   int'(irq),    1);
        check("per_busy",   int'(busy),   1);
        clear_irq();
        check("per_irq_clr", int'(irq),    0);
        check("per_exp_off", int'(expire), 0);
        step(1);
        tick = 1'b1;
        step(1);
        tick = 1'b0;
        check("per_c1b", int'(count), 1);
        tick3();
        t2 = cyc;
        check("per_exp2",   int'(expire), 1);
        check("per_irq2",   int'(irq),    1);
        check("per_period", t2 - t1,      6);
        stop = 1'b1;
        step(1);
        check("per_hold_busy", int'(busy), 1);
        step(1);
        stop = 1'b0;
        check("per_abort_busy",  int'(busy),  0);
        check("per_abort_count", int'(count), 0);
        clear_irq();

        // Pause / resume: load 5, two ticks, hold through 10 ticks
        do_start(5, 1'b0);
        tick3();
        tick3();
        check("hold_pre", int'(count), 3);
        stop = 1'b1;
        step(1);
        stop = 1'b0;
        tick = 1'b1;
        step(10);
        tick = 1'b0;
        check("hold_frozen", int'(count), 3);
        check("hold_busy",   int'(busy),  1);
        start = 1'b1;
        step(1);
        start = 1'b0;
        check("resume_noreload", int'(count), 3);
        tick3();
        check("resume_c2", int'(count), 2);
        tick3();
        check("resume_c1", int'(count), 1);
        tick3();
        check("resume_expire", int'(expire), 1);
        check("resume_busy",   int'(busy),   0);
        clear_irq();
        // Second run: abort out of HOLD
        do_start(5, 1'b0);
        tick3();
        check("abort_pre", int'(count), 4);
        stop = 1'b1;
        step(1);
        check("abort_hold", int'(busy), 1);
        step(1);
        stop = 1'b0;
        check("abort_busy",   int'(busy),   0);
        check("abort_count",  int'(count),  0);
        check("abort_expire", int'(expire), 0);
        step(1);
        check("abort_expire2", int'(expire), 0);

        // tick and stop together in RUN
        do_start(3, 1'b0);
        tick  = 1'b1;
        stop  = 1'b1;
        step(1);
        stop  = 1'b0;
        check("tickstop_count", int'(count), 3);
        check("tickstop_busy",  int'(busy),  1);
        step(1);
        tick = 1'b0;
        check("tickstop_hold_ignores_tick", int'(count), 3);
        stop = 1'b1;
        step(1);
        stop = 1'b0;

        // start and stop together in IDLE
        start    = 1'b1;
        stop     = 1'b1;
        load_val = 8'd7;
        step(1);
        start    = 1'b0;
        stop     = 1'b0;
        check("idle_startstop_busy",  int'(busy),  0);
        check("idle_startstop_count", int'(count), 0);

        // start and tick together in RUN at count 1: reload, no expiry
        do_start(2, 1'b0);
        tick3();
        check("st_tick_pre", int'(count), 1);
        start    = 1'b1;
        tick     = 1'b1;
        load_val = 8'd2;
        step(1);
        start    = 1'b0;
        tick     = 1'b0;
        check("st_tick_count",  int'(count),  2);
        check("st_tick_expire", int'(expire), 0);
        check("st_tick_busy",   int'(busy),   1);
        do_start(0, 1'b0);
        check("run_load0_busy",  int'(busy),  0);
        check("run_load0_count", int'(count), 0);

        // irq_clr coincident with expiry: set wins
        do_start(1, 1'b0);
        tick    = 1'b1;
        irq_clr = 1'b1;
        step(1);
        tick    = 1'b0;
        irq_clr = 1'b0;
        check("irq_setwins_irq",    int'(irq),    1);
        check("irq_setwins_expire", int'(expire), 1);
        clear_irq();
        check("irq_clr_after", int'(irq), 0);

        // start with load 0 in IDLE: ignored
        do_start(0, 1'b1);
        check("idle_load0_busy",  int'(busy),  0);
        check("idle_load0_count", int'(count), 0);

        // load 255 with tick held high.  expire rises 255 edges after the
        // start edge, i.e. it occupies the 256th clock period from that edge.
        tick = 1'b1;
        do_start(255, 1'b0);
        check("max_load", int'(count), 255);
        n = 0;
        while (n < 300 && !expire) begin
            step(1);
            n++;
        end
        tick = 1'b0;
        check("max_latency", n,           255);
        check("max_count",   int'(count), 0);

        // Asynchronous reset mid-run at count 2 (irq is still set here)
        do_start(3, 1'b1);
        tick3();
        check("ar_pre_count", int'(count), 2);
        check("ar_pre_irq",   int'(irq),   1);
        #2;
        res = 1'b0;
        #1;
        check("ar_count",  int'(count),  0);
        check("ar_busy",   int'(busy),   0);
        check("ar_irq",    int'(irq),    0);
        check("ar_expire", int'(expire), 0);
        step(1);
        res  = 1'b1;
        tick = 1'b1;
        step(5);
        tick = 1'b0;
        check("ar_post_count",  int'(count),  0);
        check("ar_post_busy",   int'(busy),   0);
        check("ar_post_expire", int'(expire), 0);
        step(2);

        chk_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Hard stop so the run can never hang.
    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1);
    end

endmodule
